// File: rtl/axil2native_bridge.sv
// AXI4-Lite slave to native valid/ready master bridge with registered holding slots and responses.
// Optional native-response watchdog enabled by defining AXIL2NATIVE_TIMEOUT_EN.
module axil2native_bridge #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  native_valid,
    input  logic                  native_ready,
    output logic [ADDR_WIDTH-1:0] native_addr,
    output logic [DATA_WIDTH-1:0] native_wdata,
    output logic [STRB_WIDTH-1:0] native_wstrb,
    input  logic [DATA_WIDTH-1:0] native_rdata
);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StBresp, StRresp} state_e;

    state_e state_q, state_d;

    logic                  rst_done_q;
    logic                  aw_full_q, w_full_q, ar_full_q;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  last_grant_q;  // 1: last native grant was a write
    logic                  native_valid_q;
    logic [ADDR_WIDTH-1:0] native_addr_q;
    logic [DATA_WIDTH-1:0] native_wdata_q;
    logic [STRB_WIDTH-1:0] native_wstrb_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic aw_hs, w_hs, ar_hs, wr_pend, rd_pend, grant_wr, tmo;
    logic load_wr, load_rd, wr_done, rd_done, b_done, r_done;
    logic unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    assign s_axil_awready = rst_done_q && !aw_full_q;
    assign s_axil_wready  = rst_done_q && !w_full_q;
    assign s_axil_arready = rst_done_q && !ar_full_q;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    assign wr_pend  = aw_full_q && w_full_q;
    assign rd_pend  = ar_full_q;
    assign grant_wr = wr_pend && (!rd_pend || (ARB_MODE == 0) || !last_grant_q);

`ifdef AXIL2NATIVE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;
    logic            busy;

    assign busy = (state_q == StWr) || (state_q == StRd);
    assign tmo  = busy && !native_ready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || load_wr || load_rd) begin
            cnt_q <= '0;
        end else if (busy && !native_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d = StWr;
                end else if (rd_pend) begin
                    state_d = StRd;
                end
            end
            StWr:    if (native_ready || tmo) state_d = StBresp;
            StRd:    if (native_ready || tmo) state_d = StRresp;
            StBresp: if (s_axil_bready) state_d = StIdle;
            StRresp: if (s_axil_rready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_wr = (state_q == StIdle) && (state_d == StWr);
        load_rd = (state_q == StIdle) && (state_d == StRd);
        wr_done = (state_q == StWr) && (native_ready || tmo);
        rd_done = (state_q == StRd) && (native_ready || tmo);
        b_done  = (state_q == StBresp) && s_axil_bready;
        r_done  = (state_q == StRresp) && s_axil_rready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rst_done_q     <= 1'b0;
            aw_full_q      <= 1'b0;
            w_full_q       <= 1'b0;
            ar_full_q      <= 1'b0;
            awaddr_q       <= '0;
            araddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            last_grant_q   <= 1'b0;
            native_valid_q <= 1'b0;
            native_addr_q  <= '0;
            native_wdata_q <= '0;
            native_wstrb_q <= '0;
            bvalid_q       <= 1'b0;
            bresp_q        <= 2'b00;
            rvalid_q       <= 1'b0;
            rresp_q        <= 2'b00;
            rdata_q        <= '0;
        end else begin
            rst_done_q <= 1'b1;
            if (aw_hs) begin
                awaddr_q  <= s_axil_awaddr;
                aw_full_q <= 1'b1;
            end else if (wr_done) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                wdata_q  <= s_axil_wdata;
                wstrb_q  <= s_axil_wstrb;
                w_full_q <= 1'b1;
            end else if (wr_done) begin
                w_full_q <= 1'b0;
            end
            if (ar_hs) begin
                araddr_q  <= s_axil_araddr;
                ar_full_q <= 1'b1;
            end else if (rd_done) begin
                ar_full_q <= 1'b0;
            end
            if (load_wr) begin
                native_valid_q <= 1'b1;
                native_addr_q  <= awaddr_q;
                native_wdata_q <= wdata_q;
                native_wstrb_q <= wstrb_q;
                last_grant_q   <= 1'b1;
            end else if (load_rd) begin
                native_valid_q <= 1'b1;
                native_addr_q  <= araddr_q;
                native_wstrb_q <= '0;
                last_grant_q   <= 1'b0;
            end else if (wr_done || rd_done) begin
                native_valid_q <= 1'b0;
            end
            // A ready in the watchdog expiry cycle still yields OKAY.
            if (wr_done) begin
                bvalid_q <= 1'b1;
                bresp_q  <= native_ready ? 2'b00 : 2'b10;
            end else if (b_done) begin
                bvalid_q <= 1'b0;
            end
            if (rd_done) begin
                rvalid_q <= 1'b1;
                rresp_q  <= native_ready ? 2'b00 : 2'b10;
                rdata_q  <= native_ready ? native_rdata : '0;
            end else if (r_done) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign native_valid  = native_valid_q;
    assign native_addr   = native_addr_q;
    assign native_wdata  = native_wdata_q;
    assign native_wstrb  = native_wstrb_q;
    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;

endmodule

// File: tb/tb_axil2native_bridge.sv
// Directed bench for axil2native_bridge; a second instance with ARB_MODE=1 checks round-robin.
module tb_axil2native_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] awaddr, wdata, araddr, native_rdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        nat_rdy, nat_auto;

    logic        awready, wready, arready, bvalid, rvalid, native_valid, native_ready;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, native_addr, native_wdata;
    logic [3:0]  native_wstrb;

    logic        rr_awready, rr_wready, rr_arready, rr_bvalid, rr_rvalid;
    logic        rr_native_valid, rr_native_ready;
    logic [1:0]  rr_bresp, rr_rresp;
    logic [31:0] rr_rdata, rr_native_addr, rr_native_wdata;
    logic [3:0]  rr_native_wstrb;

    assign native_ready    = nat_auto ? native_valid : nat_rdy;
    assign rr_native_ready = rr_native_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] log0[$];
    logic [31:0] log1[$];

    always @(posedge clk) begin
        if (native_valid && native_ready) log0.push_back(native_addr);
        if (rr_native_valid && rr_native_ready) log1.push_back(rr_native_addr);
    end

    axil2native_bridge #(.ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .native_valid(native_valid), .native_ready(native_ready), .native_addr(native_addr),
        .native_wdata(native_wdata), .native_wstrb(native_wstrb), .native_rdata(native_rdata)
    );

    axil2native_bridge #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid),
        .s_axil_awready(rr_awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(rr_wready),
        .s_axil_bresp(rr_bresp), .s_axil_bvalid(rr_bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid),
        .s_axil_arready(rr_arready),
        .s_axil_rdata(rr_rdata), .s_axil_rresp(rr_rresp), .s_axil_rvalid(rr_rvalid),
        .s_axil_rready(rready),
        .native_valid(rr_native_valid), .native_ready(rr_native_ready),
        .native_addr(rr_native_addr), .native_wdata(rr_native_wdata),
        .native_wstrb(rr_native_wstrb), .native_rdata(native_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; native_rdata = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; nat_rdy = 0; nat_auto = 0;
        tick(); tick();
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL reset_ready got %b want 000", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid, native_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_valid got %b want 000", {bvalid, rvalid, native_valid});
        end
        checks++;
        if ({native_addr, native_wdata, native_wstrb, rdata, bresp, rresp} !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h/%h/%b/%b want all 0",
                               native_addr, native_wdata, native_wstrb, rdata, bresp, rresp);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL post_reset_ready got %b want 111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_basic();
        awaddr = 32'h10; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        checks++;
        if ({awready, wready, native_valid} !== 3'b000) begin
            errors++; $display("FAIL wr_held got %b want 000", {awready, wready, native_valid});
        end
        tick();
        checks++;
        if ({native_valid, native_addr, native_wdata, native_wstrb} !== {1'b1, 32'h10, 32'hDEADBEEF, 4'hF}) begin
            errors++; $display("FAIL wr_native got v=%b a=%h d=%h s=%h want 1/10/deadbeef/f",
                               native_valid, native_addr, native_wdata, native_wstrb);
        end
        nat_rdy = 1;
        tick();
        nat_rdy = 0;
        checks++;
        if ({native_valid, bvalid, bresp, awready, wready} !== 6'b0_1_00_11) begin
            errors++; $display("FAIL wr_resp got v=%b b=%b r=%b rdy=%b%b want 0/1/00/11",
                               native_valid, bvalid, bresp, awready, wready);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL wr_bhold got %b want 1", bvalid);
        end
        bready = 1;
        tick();
        bready = 0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL wr_bdone got %b want 0", bvalid);
        end
    endtask

    task automatic test_w_before_aw();
        logic early;
        wdata = 32'hCAFEF00D; wstrb = 4'h3; wvalid = 1;
        tick();
        wvalid = 0;
        early = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (native_valid || wready) early = 1'b1;
            tick();
        end
        if (native_valid || wready) early = 1'b1;
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL wfirst_wait got %b want 0", early);
        end
        awaddr = 32'h20; awvalid = 1;
        tick();
        awvalid = 0;
        checks++;
        if ({native_valid, wready} !== 2'b00) begin
            errors++; $display("FAIL wfirst_aw got %b want 00", {native_valid, wready});
        end
        tick();
        checks++;
        if ({native_valid, wready, native_addr, native_wdata, native_wstrb} !==
            {1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 4'h3}) begin
            errors++; $display("FAIL wfirst_native got v=%b w=%b a=%h d=%h s=%h want 1/0/20/cafef00d/3",
                               native_valid, wready, native_addr, native_wdata, native_wstrb);
        end
        nat_rdy = 1;
        tick();
        nat_rdy = 0;
        checks++;
        if ({wready, bvalid, bresp} !== 4'b1100) begin
            errors++; $display("FAIL wfirst_done got %b want 1100", {wready, bvalid, bresp});
        end
        bready = 1; tick(); bready = 0;
    endtask

    task automatic test_read_hold();
        logic bad;
        araddr = 32'h40; arvalid = 1; native_rdata = 32'h12345678;
        tick();
        arvalid = 0;
        checks++;
        if (arready !== 1'b0) begin
            errors++; $display("FAIL rd_held got %b want 0", arready);
        end
        tick();
        checks++;
        if ({native_valid, native_addr, native_wstrb} !== {1'b1, 32'h40, 4'h0}) begin
            errors++; $display("FAIL rd_native got v=%b a=%h s=%h want 1/40/0",
                               native_valid, native_addr, native_wstrb);
        end
        nat_rdy = 1;
        tick();
        nat_rdy = 0; native_rdata = 32'h0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({rvalid, rresp, rdata, native_wstrb, native_valid} !== {1'b1, 2'b00, 32'h12345678, 4'h0, 1'b0})
                bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL rd_hold got unstable rvalid=%b rdata=%h want 1/12345678", rvalid, rdata);
        end
        rready = 1;
        tick();
        rready = 0;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            errors++; $display("FAIL rd_done got %b want 01", {rvalid, arready});
        end
    endtask

`ifdef AXIL2NATIVE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        awaddr = 32'h70; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        n = 0;
        for (int i = 0; i < 20 && native_valid; i++) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL tmo_wr_len got %0d want 8", n);
        end
        checks++;
        if ({bvalid, bresp, awready, wready} !== 5'b1_10_11) begin
            errors++; $display("FAIL tmo_wr_resp got %b want 11011", {bvalid, bresp, awready, wready});
        end
        bready = 1; tick(); bready = 0;
        araddr = 32'h74; arvalid = 1; native_rdata = 32'hFFFFFFFF;
        tick();
        arvalid = 0;
        tick();
        n = 0;
        for (int i = 0; i < 20 && native_valid; i++) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 8) begin
            errors++; $display("FAIL tmo_rd_len got %0d want 8", n);
        end
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin
            errors++; $display("FAIL tmo_rd_resp got v=%b r=%b d=%h want 1/10/0", rvalid, rresp, rdata);
        end
        rready = 1; tick(); rready = 0;
    endtask
`else
    task automatic test_timeout();
        int n;
        awaddr = 32'h70; wdata = 32'h1; wstrb = 4'h0; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (native_valid) n++;
            tick();
        end
        checks++;
        if ({n, native_wstrb} !== {32'd20, 4'h0}) begin
            errors++; $display("FAIL wait_forever got %0d cycles strb %h want 20/0", n, native_wstrb);
        end
        nat_rdy = 1; tick(); nat_rdy = 0;
        checks++;
        if ({bvalid, bresp} !== 3'b100) begin
            errors++; $display("FAIL wait_resp got %b want 100", {bvalid, bresp});
        end
        bready = 1; tick(); bready = 0;
    endtask
`endif

    task automatic test_reset_mid();
        logic bad;
        awaddr = 32'h80; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        checks++;
        if (native_valid !== 1'b1) begin
            errors++; $display("FAIL mid_valid got %b want 1", native_valid);
        end
        rst = 0;
        tick();
        checks++;
        if ({native_valid, native_addr, native_wdata, native_wstrb, awready, bvalid} !== '0) begin
            errors++; $display("FAIL mid_reset got v=%b a=%h d=%h s=%h aw=%b b=%b want 0",
                               native_valid, native_addr, native_wdata, native_wstrb, awready, bvalid);
        end
        rst = 1; nat_rdy = 1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({bvalid, native_valid, awready, wready, arready} !== 5'b00111) bad = 1'b1;
        end
        nat_rdy = 0;
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL mid_after got b=%b v=%b rdy=%b%b%b want 0/0/111",
                               bvalid, native_valid, awready, wready, arready);
        end
    endtask

    task automatic test_arbitration();
        rst = 0; tick(); rst = 1; tick();
        log0.delete(); log1.delete();
        nat_auto = 1; bready = 1; rready = 1;
        awaddr = 32'h50; wdata = 32'hA5; wstrb = 4'hF; araddr = 32'h60;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        for (int i = 0; i < 10 && !bvalid; i++) tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL arb_first_b got %b want 1", bvalid);
        end
        awaddr = 32'h54; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (log0.size() !== 3) begin
            errors++; $display("FAIL arb_fixed_n got %0d want 3", log0.size());
        end else if ({log0[0], log0[1], log0[2]} !== {32'h50, 32'h54, 32'h60}) begin
            errors++; $display("FAIL arb_fixed_order got %h %h %h want 50 54 60", log0[0], log0[1], log0[2]);
        end
        checks++;
        if (log1.size() !== 3) begin
            errors++; $display("FAIL arb_rr_n got %0d want 3", log1.size());
        end else if ({log1[0], log1[1], log1[2]} !== {32'h50, 32'h60, 32'h54}) begin
            errors++; $display("FAIL arb_rr_order got %h %h %h want 50 60 54", log1[0], log1[1], log1[2]);
        end
        nat_auto = 0; bready = 0; rready = 0;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_read_hold();
        test_timeout();
        test_reset_mid();
        test_arbitration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
